// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone width constants and arbiter state encodings shared by
// the arbiter top level and its round-robin picker.
package wb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_ERRWAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rr_picker: purely combinational round-robin selector. Scans the request
// vector upward starting one past the previous owner, wrapping at N, and
// returns the first requester as a one-hot vector plus its index.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  // First requester after 'last' in circular order wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (!win_vld && req[cand]) begin
        win_vld       = 1'b1;
        win_oh[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone slave port between
// NMASTERS masters. The winner owns the slave for its whole cyc window.
// Optional slave-hang watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ARB_IDLE    | no owner, grant = 0, arbitrate among m_cyc requesters
// ARB_BUSY    | one owner, its bus signals are muxed to the slave side
// ARB_ERRWAIT | watchdog fired, bus parked until the old owner drops cyc
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NMASTERS*ADR_W-1:0] m_adr,
  input  logic [NMASTERS*DAT_W-1:0] m_dat_w,
  input  logic [NMASTERS*SEL_W-1:0] m_sel,
  input  logic [NMASTERS-1:0]       m_we,
  input  logic [NMASTERS-1:0]       m_cyc,
  input  logic [NMASTERS-1:0]       m_stb,
  output logic [NMASTERS-1:0]       m_ack,
  output logic [NMASTERS-1:0]       m_err,
  output logic [DAT_W-1:0]          m_dat_r,
  output logic [ADR_W-1:0]          s_adr,
  output logic [DAT_W-1:0]          s_dat_w,
  output logic [SEL_W-1:0]          s_sel,
  output logic                      s_we,
  output logic                      s_cyc,
  output logic                      s_stb,
  input  logic [DAT_W-1:0]          s_dat_r,
  input  logic                      s_ack,
  output logic [NMASTERS-1:0]       grant
);

  localparam int IDX_W = $clog2(NMASTERS);

  if (NMASTERS < 2 || NMASTERS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("wb_arbiter: NMASTERS must be 2..8 and TIMEOUT 1..65535");
  end

  arb_state_t          state;
  logic [NMASTERS-1:0] grant_q;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    last;

  logic [NMASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;

  logic owner_cyc;
  logic owner_stb;
  logic wd_fire;
  logic slave_en;

  rr_picker #(
    .N     (NMASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (m_cyc),
    .last    (last),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  assign owner_cyc = m_cyc[owner];
  assign owner_stb = m_stb[owner];

  // The slave side is live only while an owner holds the bus and the
  // watchdog has not just cut it off.
  assign slave_en = (state == ARB_BUSY) && !wd_fire;

  assign grant   = grant_q;
  assign m_dat_r = s_dat_r;
  assign m_ack   = (slave_en && s_ack) ? grant_q : '0;

  // Steer the owner's request onto the slave bus; park everything at zero otherwise.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    if (slave_en) begin
      s_adr   = m_adr[int'(owner)*ADR_W +: ADR_W];
      s_dat_w = m_dat_w[int'(owner)*DAT_W +: DAT_W];
      s_sel   = m_sel[int'(owner)*SEL_W +: SEL_W];
      s_we    = m_we[owner];
      s_cyc   = owner_cyc;
      s_stb   = owner_cyc & owner_stb;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 255) ? 16 : 8;

  logic [WD_W-1:0] wdog;

  // Count stalled strobe cycles of the current owner; any ack restarts it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wdog <= '0;
    end else if (state != ARB_BUSY || s_ack) begin
      wdog <= '0;
    end else if (s_stb) begin
      wdog <= wdog + WD_W'(1);
    end
  end

  assign wd_fire = (state == ARB_BUSY) && (wdog == WD_W'(TIMEOUT));
  assign m_err   = wd_fire ? grant_q : '0;
`else
  assign wd_fire = 1'b0;
  assign m_err   = '0;
`endif

  // Arbitration FSM: grant, owner and round-robin pointer are all registered.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      owner   <= '0;
      last    <= IDX_W'(NMASTERS - 1);
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state   <= ARB_BUSY;
            grant_q <= pick_oh;
            owner   <= pick_idx;
          end
        end
        ARB_BUSY: begin
          if (!owner_cyc) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            last    <= owner;
          end
`ifdef WB_ARBITER_TIMEOUT_EN
          else if (wd_fire) begin
            state   <= ARB_ERRWAIT;
            grant_q <= '0;
          end
`endif
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        ARB_ERRWAIT: begin
          if (!owner_cyc) begin
            state <= ARB_IDLE;
            last  <= owner;
          end
        end
`endif
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with four masters and
// TIMEOUT = 8. Expected grants, acks and errors are queued as stimulus is
// driven and checked by a negedge monitor as the DUT produces them.
module tb_wb_arbiter;

  localparam int NM = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NM*32-1:0]  m_adr;
  logic [NM*32-1:0]  m_dat_w;
  logic [NM*4-1:0]   m_sel;
  logic [NM-1:0]     m_we;
  logic [NM-1:0]     m_cyc;
  logic [NM-1:0]     m_stb;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_err;
  logic [31:0]       m_dat_r;
  logic [31:0]       s_adr;
  logic [31:0]       s_dat_w;
  logic [3:0]        s_sel;
  logic              s_we;
  logic              s_cyc;
  logic              s_stb;
  logic [31:0]       s_dat_r;
  logic              s_ack;
  logic [NM-1:0]     grant;

  logic auto_ack;
  logic man_ack;
  assign s_ack = auto_ack ? s_stb : man_ack;

  always #5 sys_clk = ~sys_clk;

  wb_arbiter #(
    .NMASTERS (NM),
    .TIMEOUT  (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_we      (m_we),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .m_dat_r   (m_dat_r),
    .s_adr     (s_adr),
    .s_dat_w   (s_dat_w),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_dat_r   (s_dat_r),
    .s_ack     (s_ack),
    .grant     (grant)
  );

  typedef struct {
    int idx;
    int gap;
  } gexp_t;

  gexp_t         exp_grant_q[$];
  logic [NM-1:0] exp_ack_q[$];
  logic [NM-1:0] exp_err_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int grant_events = 0;
  int err_events = 0;
  int idle_cnt = 0;
  logic mon_en = 1'b0;
  logic ack_sb_en = 1'b0;
  logic [NM-1:0] prev_grant = '0;
  gexp_t         mon_ge;
  logic [NM-1:0] mon_vec;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = we;
    m_adr[i*32 +: 32]  = adr;
    m_dat_w[i*32 +: 32] = dat;
    m_sel[i*4 +: 4]     = 4'hf;
  endtask

  task automatic push_grant(input int idx, input int gap);
    gexp_t g;
    g.idx = idx;
    g.gap = gap;
    exp_grant_q.push_back(g);
  endtask

  task automatic clear_masters();
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    m_we = '0; m_cyc = '0; m_stb = '0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    clear_masters();
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    s_dat_r  = '0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [NM-1:0] exp);
    int k;
    k = 0;
    while (grant !== exp && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    check_val(tag, grant, exp);
  endtask

  // Scoreboard monitor: pops an expectation for each new grant, ack and error.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (grant != '0 && grant != prev_grant) begin
        grant_events++;
        if (exp_grant_q.size() == 0) begin
          check_val("grant_unexpected", grant, 0);
        end else begin
          mon_ge  = exp_grant_q.pop_front();
          mon_vec = '0;
          mon_vec[mon_ge.idx] = 1'b1;
          check_val("grant_order", grant, mon_vec);
          if (mon_ge.gap >= 0) check_val("idle_gap", idle_cnt, mon_ge.gap);
        end
      end
      idle_cnt   = (grant == '0) ? idle_cnt + 1 : 0;
      prev_grant = grant;
      if (ack_sb_en && m_ack != '0) begin
        if (exp_ack_q.size() == 0) begin
          check_val("ack_unexpected", m_ack, 0);
        end else begin
          check_val("ack_vec", m_ack, exp_ack_q.pop_front());
          check_val("ack_dat", m_dat_r, s_dat_r);
        end
      end
      if (m_err != '0) begin
        err_events++;
        if (exp_err_q.size() == 0) check_val("err_unexpected", m_err, 0);
        else check_val("err_vec", m_err, exp_err_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [NM-1:0] a;
    int start;
    int k;

    // Reset values
    do_reset();
    mon_en = 1'b1;
    @(negedge sys_clk);
    check_val("rst_grant", grant, 0);
    check_val("rst_s_cyc", s_cyc, 0);
    check_val("rst_s_stb", s_stb, 0);
    check_val("rst_s_adr", s_adr, 0);
    check_val("rst_m_ack", m_ack, 0);
    check_val("rst_m_err", m_err, 0);

    // Single master 2 read, ack three cycles after grant
    ack_sb_en = 1'b1;
    push_grant(2, -1);
    tick();
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h4000_0002, 32'h0);
    @(negedge sys_clk);
    check_val("t1_latency", grant, 0);
    @(negedge sys_clk);
    check_val("t1_grant", grant, 4'b0100);
    check_val("t1_s_adr", s_adr, 32'h4000_0002);
    check_val("t1_s_we", s_we, 0);
    check_val("t1_s_stb", s_stb, 1);
    repeat (2) tick();
    exp_ack_q.push_back(4'b0100);
    man_ack = 1'b1;
    s_dat_r = 32'hCAFE_F00D;
    tick();
    man_ack = 1'b0;
    set_master(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge sys_clk);
    check_val("t1_s_cyc_drop", s_cyc, 0);
    @(negedge sys_clk);
    check_val("t1_release", grant, 0);

    // All four requesting, slave acks immediately: 0,1,2,3,0
    do_reset();
    ack_sb_en = 1'b0;
    auto_ack  = 1'b1;
    push_grant(0, -1);
    push_grant(1, 1);
    push_grant(2, 1);
    push_grant(3, 1);
    push_grant(0, 1);
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(i), 32'h0);
    start = grant_events;
    for (int c = 0; c < 60 && grant_events < start + 5; c++) begin
      @(negedge sys_clk);
      a = m_ack;
      tick();
      m_cyc = ~a;
      m_stb = ~a;
    end
    check_val("t2_grant_count", grant_events - start, 5);
    clear_masters();
    auto_ack = 1'b0;
    repeat (3) tick();

    // Master 1 owns, master 3 waits
    do_reset();
    ack_sb_en = 1'b1;
    push_grant(1, -1);
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h1111_0000, 32'hAAAA_0001);
    tick();
    set_master(3, 1'b1, 1'b1, 1'b0, 32'h3333_0000, 32'hBBBB_0003);
    @(negedge sys_clk);
    check_val("t3_grant", grant, 4'b0010);
    check_val("t3_s_adr", s_adr, 32'h1111_0000);
    check_val("t3_s_dat_w", s_dat_w, 32'hAAAA_0001);
    check_val("t3_s_we", s_we, 1);
    tick();
    exp_ack_q.push_back(4'b0010);
    man_ack = 1'b1;
    s_dat_r = 32'h0000_5A5A;
    @(negedge sys_clk);
    check_val("t3_m_ack3", m_ack[3], 0);
    check_val("t3_s_adr_hold", s_adr, 32'h1111_0000);
    tick();
    man_ack = 1'b0;
    push_grant(3, 1);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_grant("t3_regrant", 4'b1000);
    check_val("t3_s_adr_m3", s_adr, 32'h3333_0000);
    check_val("t3_s_dat_w_m3", s_dat_w, 32'hBBBB_0003);
    clear_masters();
    repeat (3) tick();

    // s_ack with nobody on the bus
    do_reset();
    ack_sb_en = 1'b1;
    tick();
    man_ack = 1'b1;
    s_dat_r = 32'h1234_5678;
    @(negedge sys_clk);
    check_val("t4_m_ack", m_ack, 0);
    check_val("t4_grant", grant, 0);
    tick();
    man_ack = 1'b0;
    @(negedge sys_clk);
    check_val("t4_grant_after", grant, 0);

    // Reset in the middle of a write, then all masters requesting
    do_reset();
    push_grant(2, -1);
    set_master(2, 1'b1, 1'b1, 1'b1, 32'h2000_0010, 32'hDEAD_0002);
    tick();
    @(negedge sys_clk);
    check_val("t5_busy", grant, 4'b0100);
    check_val("t5_s_we", s_we, 1);
    tick();
    sys_rst_n = 1'b0;
    for (int i = 0; i < NM; i++) set_master(i, 1'b1, 1'b1, 1'b1, 32'h5000_0000 + 32'(i), 32'h0);
    tick();
    man_ack = 1'b1;
    @(negedge sys_clk);
    check_val("t5_rst_grant", grant, 0);
    check_val("t5_rst_s_cyc", s_cyc, 0);
    check_val("t5_rst_s_stb", s_stb, 0);
    check_val("t5_rst_m_ack", m_ack, 0);
    tick();
    man_ack = 1'b0;
    push_grant(0, -1);
    sys_rst_n = 1'b1;
    wait_grant("t5_first_winner", 4'b0001);
    clear_masters();
    repeat (3) tick();

    // Slave never acks
    do_reset();
    push_grant(1, -1);
`ifdef WB_ARBITER_TIMEOUT_EN
    exp_err_q.push_back(4'b0010);
`endif
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h6000_0000, 32'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_val("t6_grant", grant, 4'b0010);
    k = 0;
    for (int c = 1; c <= 30 && k == 0; c++) begin
      @(negedge sys_clk);
      if (m_err != '0) begin
        k = c;
        check_val("t6_s_cyc_at_err", s_cyc, 0);
      end
    end
`ifdef WB_ARBITER_TIMEOUT_EN
    check_val("t6_err_cycle", k, 8);
    repeat (5) @(negedge sys_clk);
    check_val("t6_no_regrant", grant, 0);
    check_val("t6_errwait_s_cyc", s_cyc, 0);
`else
    check_val("t6_no_err", k, 0);
    check_val("t6_stalled_grant", grant, 4'b0010);
    check_val("t6_stalled_s_cyc", s_cyc, 1);
`endif
    clear_masters();
    repeat (3) tick();
    @(negedge sys_clk);
    check_val("t6_idle", grant, 0);

`ifdef WB_ARBITER_TIMEOUT_EN
    check_val("err_pulses", err_events, 1);
`else
    check_val("err_pulses", err_events, 0);
`endif
    check_val("grant_q_left", exp_grant_q.size(), 0);
    check_val("ack_q_left", exp_ack_q.size(), 0);
    check_val("err_q_left", exp_err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin arbiter that shares one Wishbone slave port between NMASTERS bus masters such as the random-traffic test masters in the interconnect examples. Each master owns the slave for the whole of its `cyc` window. Slave-side address, data, select and strobe come from the granted master only. `ack` and an optional timeout `err` are steered back to that master alone. The block sits between the master array and the address decoder/slave fabric, in the `sys_clk` domain.

## Interface
- `NMASTERS`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 255: cycles without `s_ack` before abort (used only with the timeout feature).
- `sys_clk`, input, 1: system clock; all logic on rising edge.
- `sys_rst_n`, input, 1: reset, synchronous, active-low.
- `m_adr`, input, NMASTERS*32: master addresses; master i at bits [32*i+31:32*i].
- `m_dat_w`, input, NMASTERS*32: master write data, same packing.
- `m_sel`, input, NMASTERS*4: master byte selects.
- `m_we`, `m_cyc`, `m_stb`, input, NMASTERS each: per-master write enable, cycle and strobe.
- `m_ack`, output, NMASTERS: per-master acknowledge.
- `m_err`, output, NMASTERS: per-master error.
- `m_dat_r`, output, 32: read data, broadcast to all masters.
- `s_adr` (32), `s_dat_w` (32), `s_sel` (4), `s_we` (1), `s_cyc` (1), `s_stb` (1), output: slave-side bus.
- `s_dat_r`, input, 32: slave read data.
- `s_ack`, input, 1: slave acknowledge.
- `grant`, output, NMASTERS: one-hot current owner; all-zero when idle.

## Operation
- States:
  - IDLE: `grant` = 0.
  - BUSY: exactly one grant bit set.
  - ERRWAIT: exists only with the timeout feature.
- IDLE → BUSY: any `m_cyc` high. The winner is the first requester found scanning upward from (last+1) mod NMASTERS, wrapping. `last` = index of the previous owner; `last` resets to NMASTERS-1, so master 0 wins first.
- BUSY:
  - `s_adr`, `s_dat_w`, `s_sel`, `s_we` are muxed combinationally from the owner.
  - `s_cyc` = owner `m_cyc`; `s_stb` = owner `m_cyc & m_stb`.
  - `m_ack[i]` = `s_ack & grant[i]`.
  - `m_dat_r` = `s_dat_r` always.
- BUSY → IDLE: owner `m_cyc` low. `last` updates to the owner index.
- Requests from non-owners are held off (no `ack`) until re-arbitration.
- `s_ack` in IDLE or ERRWAIT is ignored; no `m_ack` is produced.
- While `grant` = 0, all slave outputs are 0.
- Reset mid-transfer: the next edge forces IDLE, `grant` = 0, `s_cyc` = `s_stb` = 0 and `last` = NMASTERS-1. Any in-flight `ack` is dropped.
- Reset values: all outputs 0.

## Timing
- Grant latency: `m_cyc` rising at edge t gives `grant`/`s_cyc` high after edge t+1. No combinational path from `m_cyc` to `grant`.
- `s_ack` → `m_ack`: combinational, same cycle.
- Release: owner drops `m_cyc` at edge t → IDLE after edge t+1. The next grant comes after edge t+2, so there is a minimum one idle cycle between owners.
- Owner dropping `m_cyc` in the same cycle as `s_ack`: the `ack` is still delivered that cycle.
- Back-to-back strobes by the owner inside one `cyc` window all stay with that owner.

## Configuration
- `WB_ARBITER_TIMEOUT_EN` defined:
  - An 8..16-bit watchdog counter clears on grant and on each `s_ack`, and increments while `s_stb` is high and `s_ack` is low.
  - When it reaches TIMEOUT, `m_err[owner]` pulses for one cycle and `s_cyc`/`s_stb` drop that cycle. State goes to ERRWAIT.
  - ERRWAIT holds `grant` = 0 until the former owner drops `m_cyc`, then returns to IDLE and updates `last`.
- Macro undefined: no counter, no ERRWAIT, `m_err` tied to 0, and a hung slave stalls the bus indefinitely.

## Structure
- Shared package `wb_pkg`: Wishbone width constants (ADR_W = 32, DAT_W = 32, SEL_W = 4) and state encodings (IDLE = 0, BUSY = 1, ERRWAIT = 2).
- One sub-module: `rr_picker`. It is purely combinational: NMASTERS request vector plus `last` index gives the one-hot winner and its index.
- The top level holds the FSM, the `last` register, the muxes and the watchdog.

## Test plan
- Single master 2, cycle with adr = 0x40000002, we = 0, `s_ack` after 3 cycles → `grant` = 0b0100 one cycle after `cyc`; `m_ack[2]` once; `m_dat_r` = `s_dat_r`; IDLE after `cyc` drops.
- All four `m_cyc` high continuously, slave acks immediately → grant order 0, 1, 2, 3, 0; one idle cycle between owners.
- Master 1 owns the bus while master 3 raises `cyc` → `s_adr`/`s_dat_w` are master 1's values until release; `m_ack[3]` stays 0 during master 1's `ack`.
- `s_ack` pulsed with no `m_cyc` high → all `m_ack` = 0; `grant` stays 0.
- `sys_rst_n` low during a BUSY write → `s_cyc` = 0 and `grant` = 0 after the next edge. With `cyc` held on all masters after reset, master 0 wins first.
- With `WB_ARBITER_TIMEOUT_EN` and TIMEOUT = 8, slave never acks → `m_err[owner]` pulses once 8 cycles after `stb`; no re-grant to that owner until its `cyc` drops. Without the macro, `m_err` stays 0.
